// File: rtl/register_file.sv
// Multi-entry register file: byte-enabled write port, two registered read
// ports with same-cycle write forwarding, optional hard-wired zero entry.
module register_file #(
    parameter int WIDTH   = 64,
    parameter int DEPTH   = 16,
    parameter int AW      = $clog2(DEPTH),
    parameter int ZERO_R0 = 1
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Clear,
    input  logic             Write,
    input  logic [AW-1:0]    WriteAddr,
    input  logic [WIDTH/8-1:0] ByteEn,
    input  logic [WIDTH-1:0] D,
    input  logic             ReadEnA,
    input  logic             ReadEnB,
    input  logic [AW-1:0]    ReadAddrA,
    input  logic [AW-1:0]    ReadAddrB,
    output logic [WIDTH-1:0] QA,
    output logic [WIDTH-1:0] QB
);

    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] nxt_a;
    logic [WIDTH-1:0] nxt_b;
    logic             wr_zero;
    logic             wr_en;
    logic             rd_zero_a;
    logic             rd_zero_b;

    assign wr_zero   = (ZERO_R0 != 0) && (WriteAddr == '0);
    assign wr_en     = Write && !Clear && (|ByteEn) && !wr_zero;
    assign rd_zero_a = (ZERO_R0 != 0) && (ReadAddrA == '0);
    assign rd_zero_b = (ZERO_R0 != 0) && (ReadAddrB == '0);

    // Post-write value of the addressed entry, shared by storage and forwarding
    always_comb begin
        merged = mem[WriteAddr];
        for (int i = 0; i < NB; i++) begin
            if (ByteEn[i]) begin
                merged[8*i +: 8] = D[8*i +: 8];
            end
        end
    end

    always_comb begin
        nxt_a = mem[ReadAddrA];
        if (rd_zero_a) begin
            nxt_a = '0;
        end else if (wr_en && (WriteAddr == ReadAddrA)) begin
            nxt_a = merged;
        end
    end

    always_comb begin
        nxt_b = mem[ReadAddrB];
        if (rd_zero_b) begin
            nxt_b = '0;
        end else if (wr_en && (WriteAddr == ReadAddrB)) begin
            nxt_b = merged;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (Clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[WriteAddr] <= merged;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            QA <= '0;
            QB <= '0;
        end else if (Clear) begin
            QA <= '0;
            QB <= '0;
        end else begin
            if (ReadEnA) begin
                QA <= nxt_a;
            end
            if (ReadEnB) begin
                QB <= nxt_b;
            end
        end
    end

endmodule
